// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and word width.
// The receive and transmit controllers both use this package.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } uart_state_t;

endpackage

// File: rtl/parity_checker.sv
// Combinational ones-count parity. Also produces the parity bit the receiver
// should see for the selected mode (even or odd).
module parity_checker
  import uart_pkg::*;
(
  input  logic [DATA_BITS-1:0] data,
  input  logic                 odd,
  output logic                 even_ones,
  output logic                 expected_pb
);

  logic [DATA_BITS:0] xor_chain;

  assign xor_chain[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_xor
      assign xor_chain[gi+1] = xor_chain[gi] ^ data[gi];
    end
  endgenerate

  assign even_ones   = ~xor_chain[DATA_BITS];
  // The parity bit makes the total count of 1s even (even mode) or odd (odd mode).
  assign expected_pb = odd ? even_ones : ~even_ones;

endmodule

// File: rtl/uart_rx_controller.sv
// UART receiver: synchronizes the serial line, samples each bit mid-period
// and presents every byte as a single-cycle valid pulse with error status.
module uart_rx_controller
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
)
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rx,
  input  logic                 i_parity_en,
  input  logic                 i_parity_odd,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int                 TIMER_W   = $clog2(CLKS_PER_BIT);
  localparam logic [TIMER_W-1:0] BIT_LAST  = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [TIMER_W-1:0] HALF_LAST = TIMER_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]         IDX_LAST  = 3'(DATA_BITS - 1);

  logic                 rx_meta_reg;
  logic                 rx_s_reg;
  uart_state_t          state_reg;
  logic [TIMER_W-1:0]   timer_reg;
  logic [2:0]           bit_idx_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_en_reg;
  logic                 par_odd_reg;
  logic                 par_err_reg;
  logic                 even_ones;
  logic                 expected_pb;

  // Line idles high, so the synchronizer resets to 1 to avoid a false start.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
    end else begin
      rx_meta_reg <= i_rx;
      rx_s_reg    <= rx_meta_reg;
    end
  end

  parity_checker u_parity_checker (
    .data        (shift_reg),
    .odd         (par_odd_reg),
    .even_ones   (even_ones),
    .expected_pb (expected_pb)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg    <= ST_IDLE;
      timer_reg    <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      par_en_reg   <= 1'b0;
      par_odd_reg  <= 1'b0;
      par_err_reg  <= 1'b0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (!rx_s_reg) begin
            state_reg   <= ST_START;
            timer_reg   <= '0;
            bit_idx_reg <= '0;
            par_en_reg  <= i_parity_en;
            par_odd_reg <= i_parity_odd;
            par_err_reg <= 1'b0;
            o_busy      <= 1'b1;
          end
        end

        ST_START: begin
          if (timer_reg == HALF_LAST) begin
            timer_reg <= '0;
            if (!rx_s_reg) begin
              state_reg <= ST_DATA;
            end else begin
              state_reg <= ST_IDLE;
              o_busy    <= 1'b0;
            end
          end else begin
            timer_reg <= timer_reg + TIMER_W'(1);
          end
        end

        ST_DATA: begin
          if (timer_reg == BIT_LAST) begin
            timer_reg   <= '0;
            shift_reg   <= {rx_s_reg, shift_reg[DATA_BITS-1:1]};
            bit_idx_reg <= bit_idx_reg + 3'd1;
            if (bit_idx_reg == IDX_LAST) begin
              state_reg <= par_en_reg ? ST_PARITY : ST_STOP;
            end
          end else begin
            timer_reg <= timer_reg + TIMER_W'(1);
          end
        end

        ST_PARITY: begin
          if (timer_reg == BIT_LAST) begin
            timer_reg   <= '0;
            par_err_reg <= (rx_s_reg != expected_pb);
            state_reg   <= ST_STOP;
          end else begin
            timer_reg <= timer_reg + TIMER_W'(1);
          end
        end

        ST_STOP: begin
          // Leaving at mid-stop gives half a bit of slack for a back-to-back start.
          if (timer_reg == BIT_LAST) begin
            timer_reg    <= '0;
            o_valid      <= 1'b1;
            o_data       <= shift_reg;
            o_parity_err <= par_err_reg;
            o_frame_err  <= ~rx_s_reg;
            if (rx_s_reg) begin
              state_reg <= ST_IDLE;
              o_busy    <= 1'b0;
            end else begin
              state_reg <= ST_BREAK;
            end
          end else begin
            timer_reg <= timer_reg + TIMER_W'(1);
          end
        end

        ST_BREAK: begin
          if (rx_s_reg) begin
            state_reg <= ST_IDLE;
            o_busy    <= 1'b0;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
          o_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_rx_controller.md
Name: uart_rx_controller

Overview:
- UART receive controller for the UART datapath. Oversamples the serial line, sequences start, data, parity and stop bits, and assembles an 8-bit word.
- Drives one instance of the existing parity_checker, a combinational ones-count block whose output is 1 when the word holds an even number of 1s.
- Delivers each received byte to the FPGA-side interface as a one-cycle valid pulse with parity and framing status.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit. Legal values are 4 and above; 868 gives 115200 baud at 100 MHz.

Ports:
- i_clk  input  1  system clock
- i_rst_n  input  1  synchronous active-low reset
- i_rx  input  1  serial line, asynchronous, idles high
- i_parity_en  input  1  1 = frame carries a parity bit after the data bits
- i_parity_odd  input  1  1 = odd parity, 0 = even parity; ignored when i_parity_en=0
- o_data  output  8  last received byte, LSB first on the wire
- o_valid  output  1  one-cycle pulse: o_data and the error flags are updated
- o_parity_err  output  1  parity mismatch in the last frame
- o_frame_err  output  1  stop bit sampled low in the last frame
- o_busy  output  1  high in every state except IDLE

Behaviour:
- Reset: i_rst_n sampled low on i_clk forces the following, whatever state the FSM is in:
  - FSM to IDLE.
  - All counters to 0.
  - o_data=0x00, o_valid=0, o_parity_err=0, o_frame_err=0, o_busy=0.
  - Both synchronizer flops to 1.
- Synchronizer: i_rx passes through a 2-flop synchronizer (rx_s). All decisions use rx_s.
- Bit timer: counts 0..CLKS_PER_BIT-1. Width is clog2(CLKS_PER_BIT).
- Bit index: 3 bits.
- Shift register: 8 bits, right-shifting; each new bit enters at bit 7.
- FSM states:
  - IDLE: rx_s=0 -> START. i_parity_en and i_parity_odd are latched on this cycle and held for the whole frame.
  - START: waits CLKS_PER_BIT/2 cycles (integer division) to reach mid-bit, then samples. rx_s=0 -> DATA with the timer cleared. rx_s=1 is a glitch -> IDLE with no output activity.
  - DATA: waits CLKS_PER_BIT cycles, then samples rx_s into the shift register. After bit index 7: go to PARITY if parity is latched enabled, else STOP.
  - PARITY: waits CLKS_PER_BIT cycles, then samples the received parity bit pb.
    - parity_checker input is the shift register; its output is even_ones.
    - Expected pb: even mode = ~even_ones; odd mode = even_ones.
    - Mismatch sets an internal parity-error flag.
  - STOP: waits CLKS_PER_BIT cycles, then samples and updates outputs on the same edge:
    - o_valid=1 for exactly one cycle.
    - o_data = shift register.
    - o_parity_err = internal parity flag (0 when parity is disabled).
    - o_frame_err = ~rx_s.
    - Next state: if rx_s=1 -> IDLE; else -> BREAK.
  - BREAK: stays until rx_s=1, then -> IDLE. No start detection is possible in this state.
- Output holding: o_data, o_parity_err and o_frame_err hold until the next o_valid.
- Timing: o_valid is asserted no later than (9.5 + parity_en) * CLKS_PER_BIT + 4 cycles after i_rx falls.
- Back-to-back frames: a start bit arriving immediately after the stop-bit mid-sample is detected, because the FSM returns to IDLE half a bit early.
- Config changes mid-frame: ignored; the latched values apply until the frame ends.
- No backpressure: o_valid is not held for the consumer. A consumer that misses the pulse loses the byte.

Decomposition:
- Shared package (uart_pkg): the state encoding for IDLE/START/DATA/PARITY/STOP/BREAK and the DATA_BITS=8 constant. The same package is reused by the transmit controller.
- Sub-module: parity_checker, instantiated once. The parity expected-value mux stays inside this block.

Test Plan:
All scenarios use CLKS_PER_BIT=16.
- Frame 0xA5, no parity, stop=1 -> a single o_valid pulse with o_data=0xA5, o_parity_err=0, o_frame_err=0; o_busy returns to 0 afterwards.
- Even parity:
  - 0x03 with pb=0 -> o_valid, o_data=0x03, o_parity_err=0.
  - Same frame with pb=1 -> o_parity_err=1, o_data=0x03.
- Odd parity:
  - 0x07 with pb=0 -> o_parity_err=0.
  - 0x00 with pb=0 -> o_parity_err=1.
  - Toggling i_parity_odd mid-frame has no effect on either result.
- Glitch: i_rx low for 4 cycles, then high -> no o_valid; o_busy falls within 8+3 cycles of the glitch start; a following valid frame 0x5A is received correctly.
- Break: frame 0xFF with stop=0 and the line held low for 40 bit times -> exactly one o_valid with o_frame_err=1; no further o_valid; a 0x12 frame sent after the line rises is received with o_frame_err=0.
- Reset: i_rst_n asserted during DATA bit 4 -> the next cycle shows all outputs 0 and FSM in IDLE; a following 0x3C frame is received correctly. Two back-to-back frames 0x01 and 0x80 with no idle gap -> two o_valid pulses carrying 0x01 then 0x80.
